aux_input_conditioner: RTL and testbench
========================================

Name: aux_input_conditioner

Overview:
- Conditions raw board inputs (16 slide switches, resume push-button) before they reach the top-level core/display logic.
- Per channel: synchronises to `clk`, debounces, and registers the result.
- Produces a single-cycle `resume_pulse` for the halt/resume enable logic, plus a `swt_changed` strobe.
- Sits between the board pins and the top-level `swt`/`resume` consumers.

Parameters:
- DebounceCnt, 1000000, consecutive stable `clk` cycles required to accept a new level (10 ms at 100 MHz); must be >= 2.
- SyncStages, 2, synchroniser flop depth per input; must be >= 2.

Ports:
- clk  input  1  board clock
- rst_n  input  1  asynchronous active-low reset
- resume_raw  input  1  unsynchronised push-button level
- swt_raw  input  16  unsynchronised switch levels
- swt  output  16  debounced switch levels
- resume_level  output  1  debounced button level
- resume_pulse  output  1  one-cycle pulse on debounced rising edge of button
- swt_changed  output  1  one-cycle pulse when any debounced switch bit changed

Behaviour:
- Reset (async assert, sync use on release): every synchroniser flop, counter and output clears to 0. `swt` = 16'h0000, `resume_level` = 0, `resume_pulse` = 0, `swt_changed` = 0.
- Synchroniser: each of the 17 inputs passes through a SyncStages-deep flop chain. The last stage is `s`.
- Debounce, one instance per channel:
  - Holds output level `q` and counter `c`; `c` width is clog2(DebounceCnt+1).
  - If `s == q`: `c <= 0`.
  - Else if `c == DebounceCnt-1`: `q <= s`, `c <= 0`.
  - Else: `c <= c+1`.
- Glitch rule: any cycle with `s == q` restarts the count. A bounce shorter than DebounceCnt cycles never changes `q`.
- Latency: a clean raw step (setup met) appears on `q` exactly SyncStages+DebounceCnt rising edges later.
- `resume_pulse`:
  - Registered: high in the cycle after `resume_level` goes 0->1, for exactly one cycle.
  - Nothing on a falling edge.
  - Holding the button generates no further pulses.
- `swt_changed`: registered; high for exactly one cycle in the cycle after any `swt` bit updates. Several bits updating in the same cycle give one pulse.
- Channels are independent. Simultaneous updates on `resume` and switches are all honoured in the same cycle.
- Reset mid-count discards the partial count; outputs return to 0.
- Button held through reset release: `resume_level` rises after the full latency and `resume_pulse` fires once. This is intended.
- No wrap-around is possible: the counter never exceeds DebounceCnt-1.

Decomposition:
- Shared header: add a `DEBOUNCE_CNT` default built from the existing `CNT_*` frequency macros. Add no other new constants.
- Sub-module `aux_debounce_bit` (params DebounceCnt, SyncStages; ports clk, rst_n, din, dout). Instantiate it 17 times via generate.
- Edge and pulse registers stay in the top of this block.

Test Plan (DebounceCnt=4, SyncStages=2 for simulation):
- Reset with `swt_raw` = 16'hFFFF, `resume_raw` = 1:
  - During reset, all outputs are 0.
  - After release, `swt` = 16'hFFFF and `resume_level` = 1 at edge 6.
  - `resume_pulse` is high only at edge 7.
  - `swt_changed` is high only at edge 7.
- `swt_raw[3]` 0->1 clean:
  - `swt` goes 16'h0000->16'h0008 exactly 6 edges later.
  - `swt_changed` pulses once, one cycle after.
- `resume_raw` bounce 1,0,1,0 for 1 cycle each, then steady 1:
  - `resume_level` rises only 6 edges after the final steady 1.
  - Exactly one `resume_pulse`.
- `resume_raw` high pulse of 3 cycles (< DebounceCnt): `resume_level`, `resume_pulse` and counter return stay 0/idle throughout.
- `swt_raw` 16'h0000->16'h00F0 and `resume_raw` 0->1 on the same cycle:
  - `swt` = 16'h00F0 and `resume_level` = 1 on the same edge.
  - A single `swt_changed` and a single `resume_pulse` on the next cycle.
- `rst_n` asserted mid-count (after 2 stable cycles of `swt_raw[0]`=1):
  - Outputs stay 0.
  - After release, full 6-edge latency is required again.

Source files
------------

// File: rtl/aux_input_conditioner_pkg.sv
// Shared constants and helpers for the auxiliary board-input conditioner.
package aux_input_conditioner_pkg;

  // 10 ms of stable level at the 100 MHz board clock.
  localparam int unsigned DEBOUNCE_CNT = 1_000_000;

  typedef logic [15:0] swt_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/aux_debounce_bit.sv
// One input channel: synchroniser chain followed by a restart-on-agreement debouncer.
module aux_debounce_bit
  import aux_input_conditioner_pkg::*;
#(
  parameter int unsigned DebounceCnt = DEBOUNCE_CNT,
  parameter int unsigned SyncStages  = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned      CntW    = cnt_width(DebounceCnt);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCnt - 1);

  logic [SyncStages-1:0] sync_q;
  logic                  s;
  logic                  q;
  logic [CntW-1:0]       c;

  assign s    = sync_q[SyncStages-1];
  assign dout = q;

  // Any cycle where the synchronised level agrees with q restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      q      <= 1'b0;
      c      <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], din};
      if (s == q) begin
        c <= '0;
      end else if (c == CntLast) begin
        q <= s;
        c <= '0;
      end else begin
        c <= c + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/aux_input_conditioner.sv
// Debounces the 16 slide switches and the resume button; emits resume and switch-change strobes.
module aux_input_conditioner
  import aux_input_conditioner_pkg::*;
#(
  parameter int unsigned DebounceCnt = DEBOUNCE_CNT,
  parameter int unsigned SyncStages  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        resume_raw,
  input  logic [15:0] swt_raw,
  output logic [15:0] swt,
  output logic        resume_level,
  output logic        resume_pulse,
  output logic        swt_changed
);

  // Bit 16 carries the resume button, bits 15:0 the switches.
  logic [16:0] raw_all;
  logic [16:0] deb_all;

  assign raw_all = {resume_raw, swt_raw};

  for (genvar i = 0; i < 17; i++) begin : gen_chan
    aux_debounce_bit #(
      .DebounceCnt(DebounceCnt),
      .SyncStages (SyncStages)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (raw_all[i]),
      .dout (deb_all[i])
    );
  end

  assign swt          = deb_all[15:0];
  assign resume_level = deb_all[16];

  logic resume_prev_q;
  swt_t swt_prev_q;
  logic resume_pulse_q;
  logic swt_changed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resume_prev_q  <= 1'b0;
      swt_prev_q     <= '0;
      resume_pulse_q <= 1'b0;
      swt_changed_q  <= 1'b0;
    end else begin
      resume_prev_q  <= resume_level;
      swt_prev_q     <= swt;
      resume_pulse_q <= resume_level & ~resume_prev_q;
      swt_changed_q  <= (swt != swt_prev_q);
    end
  end

  assign resume_pulse = resume_pulse_q;
  assign swt_changed  = swt_changed_q;

endmodule

// File: tb/tb_aux_input_conditioner.sv
// Scoreboard bench: stimulus queues expected output events, a monitor pops them as they appear.
module tb_aux_input_conditioner;

  logic        clk;
  logic        rst_n;
  logic        resume_raw;
  logic [15:0] swt_raw;
  logic [15:0] swt;
  logic        resume_level;
  logic        resume_pulse;
  logic        swt_changed;

  aux_input_conditioner #(
    .DebounceCnt(4),
    .SyncStages (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .resume_raw  (resume_raw),
    .swt_raw     (swt_raw),
    .swt         (swt),
    .resume_level(resume_level),
    .resume_pulse(resume_pulse),
    .swt_changed (swt_changed)
  );

  localparam int unsigned Lat = 6;

  typedef struct {
    int unsigned edge_no;
    logic [15:0] val;
  } ev_t;

  ev_t q_swt[$];
  ev_t q_lvl[$];
  ev_t q_pls[$];
  ev_t q_chg[$];

  int          checks = 0;
  int          errors = 0;
  int unsigned edge_n = 0;
  string       names[4] = '{"swt", "resume_level", "resume_pulse", "swt_changed"};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic expect_ev(input int kind, input int unsigned e, input logic [15:0] v);
    ev_t ev;
    ev.edge_no = e;
    ev.val     = v;
    case (kind)
      0:       q_swt.push_back(ev);
      1:       q_lvl.push_back(ev);
      2:       q_pls.push_back(ev);
      default: q_chg.push_back(ev);
    endcase
  endtask

  task automatic pop_ev(input int kind, input logic [15:0] act);
    ev_t ev;
    bit  have;
    have = 1'b0;
    case (kind)
      0:       if (q_swt.size() > 0) begin ev = q_swt.pop_front(); have = 1'b1; end
      1:       if (q_lvl.size() > 0) begin ev = q_lvl.pop_front(); have = 1'b1; end
      2:       if (q_pls.size() > 0) begin ev = q_pls.pop_front(); have = 1'b1; end
      default: if (q_chg.size() > 0) begin ev = q_chg.pop_front(); have = 1'b1; end
    endcase
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL unexpected %s event: got %h at edge %0d, required no event",
               names[kind], act, edge_n);
    end else if (ev.edge_no != edge_n || ev.val !== act) begin
      errors++;
      $display("FAIL %s event: got %h at edge %0d, required %h at edge %0d",
               names[kind], act, edge_n, ev.val, ev.edge_no);
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic chk_empty(input string nm, input int n);
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL %s pending: got %0d events never seen, required 0", nm, n);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge and matches every output event.
  initial begin
    logic [15:0] prev_swt;
    logic        prev_lvl;
    prev_swt = '0;
    prev_lvl = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (swt !== prev_swt)         pop_ev(0, swt);
        if (resume_level !== prev_lvl) pop_ev(1, {15'b0, resume_level});
        if (resume_pulse !== 1'b0)     pop_ev(2, {15'b0, resume_pulse});
        if (swt_changed !== 1'b0)      pop_ev(3, {15'b0, swt_changed});
      end
      prev_swt = swt;
      prev_lvl = resume_level;
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int unsigned t;
    rst_n      = 1'b0;
    swt_raw    = 16'hFFFF;
    resume_raw = 1'b1;

    // Reset with all inputs high.
    wait_neg(3);
    chk("reset swt", swt, 16'h0000);
    chk("reset resume_level", {15'b0, resume_level}, 16'h0);
    chk("reset resume_pulse", {15'b0, resume_pulse}, 16'h0);
    chk("reset swt_changed", {15'b0, swt_changed}, 16'h0);
    wait_neg(1);
    t = edge_n;
    rst_n = 1'b1;
    expect_ev(0, t + Lat, 16'hFFFF);
    expect_ev(1, t + Lat, 16'h1);
    expect_ev(2, t + Lat + 1, 16'h1);
    expect_ev(3, t + Lat + 1, 16'h1);
    wait_neg(12);

    // Return everything low; no pulse on a falling resume edge.
    t = edge_n;
    swt_raw    = 16'h0000;
    resume_raw = 1'b0;
    expect_ev(0, t + Lat, 16'h0000);
    expect_ev(1, t + Lat, 16'h0);
    expect_ev(3, t + Lat + 1, 16'h1);
    wait_neg(10);

    // Clean step on switch 3.
    t = edge_n;
    swt_raw = 16'h0008;
    expect_ev(0, t + Lat, 16'h0008);
    expect_ev(3, t + Lat + 1, 16'h1);
    wait_neg(10);

    // Bouncing button, then steady high.
    resume_raw = 1'b1; wait_neg(1);
    resume_raw = 1'b0; wait_neg(1);
    resume_raw = 1'b1; wait_neg(1);
    resume_raw = 1'b0; wait_neg(1);
    t = edge_n;
    resume_raw = 1'b1;
    expect_ev(1, t + Lat, 16'h1);
    expect_ev(2, t + Lat + 1, 16'h1);
    wait_neg(14);
    chk("held button level", {15'b0, resume_level}, 16'h1);

    t = edge_n;
    resume_raw = 1'b0;
    expect_ev(1, t + Lat, 16'h0);
    wait_neg(10);

    // Three-cycle glitch is rejected.
    resume_raw = 1'b1; wait_neg(3);
    resume_raw = 1'b0; wait_neg(12);
    chk("glitch resume_level", {15'b0, resume_level}, 16'h0);

    t = edge_n;
    swt_raw = 16'h0000;
    expect_ev(0, t + Lat, 16'h0000);
    expect_ev(3, t + Lat + 1, 16'h1);
    wait_neg(10);

    // Simultaneous switch and button updates.
    t = edge_n;
    swt_raw    = 16'h00F0;
    resume_raw = 1'b1;
    expect_ev(0, t + Lat, 16'h00F0);
    expect_ev(1, t + Lat, 16'h1);
    expect_ev(2, t + Lat + 1, 16'h1);
    expect_ev(3, t + Lat + 1, 16'h1);
    wait_neg(10);

    t = edge_n;
    swt_raw    = 16'h0000;
    resume_raw = 1'b0;
    expect_ev(0, t + Lat, 16'h0000);
    expect_ev(1, t + Lat, 16'h0);
    expect_ev(3, t + Lat + 1, 16'h1);
    wait_neg(10);

    // Reset in the middle of a count discards it.
    swt_raw = 16'h0001;
    wait_neg(3);
    rst_n = 1'b0;
    wait_neg(1);
    chk("mid-count reset swt", swt, 16'h0000);
    wait_neg(2);
    chk("mid-count reset swt_changed", {15'b0, swt_changed}, 16'h0);
    t = edge_n;
    rst_n = 1'b1;
    expect_ev(0, t + Lat, 16'h0001);
    expect_ev(3, t + Lat + 1, 16'h1);
    wait_neg(12);

    chk_empty(names[0], q_swt.size());
    chk_empty(names[1], q_lvl.size());
    chk_empty(names[2], q_pls.size());
    chk_empty(names[3], q_chg.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
